// File: rtl/otter_mem_pkg.sv
// Shared types for the backing-memory port arbiter.
package otter_mem_pkg;
  localparam int DEF_WORDS_PER_LINE = 4;

  typedef enum logic [2:0] {IDLE, ADDR, RBURST, WBURST, DONE} arb_state_t;
  typedef enum logic {REQ_IC, REQ_DC} requester_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between the I-cache and D-cache refill paths.
module rr_arbiter2 (
  input  logic req_ic,
  input  logic req_dc,
  input  logic last_dc,
  output logic gnt_vld,
  output logic gnt_dc
);
  always_comb begin
    gnt_vld = req_ic | req_dc;
    gnt_dc  = 1'b0;
    if (req_ic && req_dc) gnt_dc = ~last_dc;
    else if (req_dc)      gnt_dc = 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single backing-memory port between I-cache refills and D-cache
// refills/write-backs; each grant runs one address phase plus a full-line burst.
module mem_port_arbiter
  import otter_mem_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int OFFSET_BITS    = $clog2(WORDS_PER_LINE) + 2
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              IC_REQ,
  input  logic [31:0]                       IC_ADDR,
  output logic [31:0]                       IC_RDATA,
  output logic                              IC_RVALID,
  output logic                              IC_DONE,
  input  logic                              DC_REQ,
  input  logic                              DC_WE,
  input  logic [31:0]                       DC_ADDR,
  input  logic [31:0]                       DC_WDATA,
  output logic [31:0]                       DC_RDATA,
  output logic                              DC_RVALID,
  output logic                              DC_DONE,
  output logic [$clog2(WORDS_PER_LINE)-1:0] BEAT_IDX,
  output logic                              BUSY,
  output logic                              MM_REQ,
  output logic                              MM_WE,
  output logic [31:0]                       MM_ADDR,
  input  logic                              MM_ACK,
  output logic [31:0]                       MM_WDATA,
  output logic                              MM_WVALID,
  input  logic                              MM_WREADY,
  input  logic [31:0]                       MM_RDATA,
  input  logic                              MM_RVALID
);
  localparam int              BW        = $clog2(WORDS_PER_LINE);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(WORDS_PER_LINE - 1);
  localparam logic [31:0]     LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  arb_state_t    state;
  requester_t    owner;
  requester_t    last_grant;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [BW-1:0] beat;

  logic        gnt_vld, gnt_dc;
  logic [31:0] sel_addr;

  rr_arbiter2 u_rr (
    .req_ic  (IC_REQ),
    .req_dc  (DC_REQ),
    .last_dc (last_grant == REQ_DC),
    .gnt_vld (gnt_vld),
    .gnt_dc  (gnt_dc)
  );

  assign sel_addr = gnt_dc ? DC_ADDR : IC_ADDR;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      owner      <= REQ_IC;
      last_grant <= REQ_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat       <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          owner      <= gnt_dc ? REQ_DC : REQ_IC;
          last_grant <= gnt_dc ? REQ_DC : REQ_IC;
          we_q       <= gnt_dc & DC_WE;
          addr_q     <= sel_addr & LINE_MASK;
          beat       <= '0;
          state      <= ADDR;
        end
        ADDR: if (MM_ACK) begin
          beat  <= '0;
          state <= we_q ? WBURST : RBURST;
        end
        RBURST: if (MM_RVALID) begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= DONE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        WBURST: if (MM_WREADY) begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= DONE;
          end else begin
            beat <= beat + BW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read beats are forwarded combinationally so the cache sees data the cycle memory returns it.
  logic rd_fire;
  assign rd_fire   = (state == RBURST) && MM_RVALID;
  assign IC_RVALID = rd_fire && (owner == REQ_IC);
  assign DC_RVALID = rd_fire && (owner == REQ_DC);
  assign IC_RDATA  = IC_RVALID ? MM_RDATA : '0;
  assign DC_RDATA  = DC_RVALID ? MM_RDATA : '0;
  assign IC_DONE   = (state == DONE) && (owner == REQ_IC);
  assign DC_DONE   = (state == DONE) && (owner == REQ_DC);

  assign BEAT_IDX  = beat;
  assign BUSY      = (state != IDLE);
  assign MM_REQ    = (state == ADDR);
  assign MM_WE     = BUSY & we_q;
  assign MM_ADDR   = BUSY ? addr_q : '0;
  assign MM_WVALID = (state == WBURST);
  assign MM_WDATA  = MM_WVALID ? DC_WDATA : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: the bench plays the memory and predicts
// grants, addresses and beat sequences from the arbitration and burst rules.
module tb_mem_port_arbiter;
  localparam int W   = 4;
  localparam int BWI = $clog2(W);
  typedef logic [BWI-1:0] bidx_t;
  localparam logic [31:0] MASK = ~((32'd1 << (BWI + 2)) - 32'd1);

  logic CLK = 1'b0, RST_N = 1'b0;
  logic IC_REQ = 0, DC_REQ = 0, DC_WE = 0, MM_ACK = 0, MM_WREADY = 0, MM_RVALID = 0;
  logic [31:0] IC_ADDR = '0, DC_ADDR = '0, DC_WDATA = '0, MM_RDATA = '0;
  logic [31:0] IC_RDATA, DC_RDATA, MM_ADDR, MM_WDATA;
  logic IC_RVALID, IC_DONE, DC_RVALID, DC_DONE, BUSY, MM_REQ, MM_WE, MM_WVALID;
  logic [BWI-1:0] BEAT_IDX;

  logic DC_REQ_8 = 0, MM_ACK_8 = 0, MM_RVALID_8 = 0;
  logic [31:0] DC_ADDR_8 = '0, MM_RDATA_8 = '0;
  logic [31:0] IC_RDATA_8, DC_RDATA_8, MM_ADDR_8, MM_WDATA_8;
  logic IC_RVALID_8, IC_DONE_8, DC_RVALID_8, DC_DONE_8, BUSY_8, MM_REQ_8, MM_WE_8, MM_WVALID_8;
  logic [2:0] BEAT_IDX_8;

  int tests = 0, fails = 0;
  bit last_dc = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.WORDS_PER_LINE(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IC_REQ(IC_REQ), .IC_ADDR(IC_ADDR), .IC_RDATA(IC_RDATA), .IC_RVALID(IC_RVALID), .IC_DONE(IC_DONE),
    .DC_REQ(DC_REQ), .DC_WE(DC_WE), .DC_ADDR(DC_ADDR), .DC_WDATA(DC_WDATA),
    .DC_RDATA(DC_RDATA), .DC_RVALID(DC_RVALID), .DC_DONE(DC_DONE),
    .BEAT_IDX(BEAT_IDX), .BUSY(BUSY), .MM_REQ(MM_REQ), .MM_WE(MM_WE), .MM_ADDR(MM_ADDR),
    .MM_ACK(MM_ACK), .MM_WDATA(MM_WDATA), .MM_WVALID(MM_WVALID), .MM_WREADY(MM_WREADY),
    .MM_RDATA(MM_RDATA), .MM_RVALID(MM_RVALID)
  );

  mem_port_arbiter #(.WORDS_PER_LINE(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N),
    .IC_REQ(1'b0), .IC_ADDR(32'h0), .IC_RDATA(IC_RDATA_8), .IC_RVALID(IC_RVALID_8), .IC_DONE(IC_DONE_8),
    .DC_REQ(DC_REQ_8), .DC_WE(1'b0), .DC_ADDR(DC_ADDR_8), .DC_WDATA(32'h0),
    .DC_RDATA(DC_RDATA_8), .DC_RVALID(DC_RVALID_8), .DC_DONE(DC_DONE_8),
    .BEAT_IDX(BEAT_IDX_8), .BUSY(BUSY_8), .MM_REQ(MM_REQ_8), .MM_WE(MM_WE_8), .MM_ADDR(MM_ADDR_8),
    .MM_ACK(MM_ACK_8), .MM_WDATA(MM_WDATA_8), .MM_WVALID(MM_WVALID_8), .MM_WREADY(1'b0),
    .MM_RDATA(MM_RDATA_8), .MM_RVALID(MM_RVALID_8)
  );

  task automatic step;
    @(posedge CLK); #1;
  endtask

  // Round-robin rule: a lone requester wins; on contention the one not granted last wins.
  function automatic bit pick_dc(input bit ic, input bit dc);
    if (ic && dc) return !last_dc;
    return dc;
  endfunction

  // Called in an IDLE cycle with requests already driven; the grant happens on the next edge.
  task automatic do_burst(input bit exp_dc, input bit exp_we, input logic [31:0] exp_addr,
                          input int ack_dly, input int gap_pct, input bit rv_in_addr, input bit stall_plan);
    int beat, cyc, stalls;
    bit rv, wr, ov, xv;
    logic [31:0] d, wd, od, xd;
    step;
    tests++;
    if (MM_REQ !== 1'b1 || MM_ADDR !== exp_addr || MM_WE !== exp_we || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL addr_phase: req=%b addr=%h we=%b busy=%b, want 1 %h %b 1", MM_REQ, MM_ADDR, MM_WE, BUSY, exp_addr, exp_we);
    end
    for (int i = 0; i < ack_dly; i++) begin
      MM_RVALID = rv_in_addr; MM_RDATA = 32'hDEAD_0000 + i; #1;
      tests++;
      if (IC_RVALID !== 1'b0 || DC_RVALID !== 1'b0 || MM_REQ !== 1'b1 || MM_ADDR !== exp_addr) begin
        fails++;
        $display("FAIL addr_hold: icv=%b dcv=%b req=%b addr=%h, want 0 0 1 %h", IC_RVALID, DC_RVALID, MM_REQ, MM_ADDR, exp_addr);
      end
      step;
    end
    MM_RVALID = 0; MM_ACK = 1;
    step;
    MM_ACK = 0;
    beat = 0; cyc = 0; stalls = 0;
    while (beat < W && cyc < 200) begin
      cyc++;
      if (!exp_we) begin
        rv = ($urandom_range(0, 99) >= gap_pct);
        d = $urandom;
        MM_RVALID = rv; MM_RDATA = d; #1;
        if (exp_dc) begin ov = DC_RVALID; od = DC_RDATA; xv = IC_RVALID; xd = IC_RDATA; end
        else        begin ov = IC_RVALID; od = IC_RDATA; xv = DC_RVALID; xd = DC_RDATA; end
        tests++;
        if (ov !== rv || od !== (rv ? d : 32'h0) || xv !== 1'b0 || xd !== 32'h0 || BEAT_IDX !== bidx_t'(beat)) begin
          fails++;
          $display("FAIL rd_beat%0d: v=%b d=%h other=%b/%h idx=%0d, want v=%b d=%h other=0/0 idx=%0d",
                   beat, ov, od, xv, xd, BEAT_IDX, rv, rv ? d : 32'h0, beat);
        end
        if (rv) beat++;
      end else begin
        if (stall_plan) wr = !((beat == 1 || beat == 2) && stalls < 3);
        else            wr = ($urandom_range(0, 99) >= gap_pct);
        wd = 32'hB0 + beat;
        DC_WDATA = wd; MM_WREADY = wr; #1;
        tests++;
        if (MM_WVALID !== 1'b1 || MM_WDATA !== wd || BEAT_IDX !== bidx_t'(beat) || MM_REQ !== 1'b0) begin
          fails++;
          $display("FAIL wr_beat%0d: wv=%b wdata=%h idx=%0d req=%b, want 1 %h %0d 0", beat, MM_WVALID, MM_WDATA, BEAT_IDX, MM_REQ, wd, beat);
        end
        if (wr) begin beat++; stalls = 0; end
        else stalls++;
      end
      step;
    end
    MM_RVALID = 0; MM_WREADY = 0;
    tests++;
    if (beat != W || IC_DONE !== !exp_dc || DC_DONE !== exp_dc || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: beats=%0d ic_done=%b dc_done=%b busy=%b, want %0d %b %b 1", beat, IC_DONE, DC_DONE, BUSY, W, !exp_dc, exp_dc);
    end
    step;
    tests++;
    if ({IC_DONE, DC_DONE, BUSY, MM_REQ, MM_WVALID} !== 5'b0) begin
      fails++;
      $display("FAIL idle_after: done=%b%b busy=%b req=%b wv=%b, want all 0", IC_DONE, DC_DONE, BUSY, MM_REQ, MM_WVALID);
    end
    last_dc = exp_dc;
  endtask

  task automatic test_reset;
    RST_N = 0; MM_RVALID = 1; MM_ACK = 1; MM_WREADY = 1; MM_RDATA = $urandom; DC_WDATA = $urandom;
    step; step;
    tests++;
    if ({IC_RDATA, IC_RVALID, IC_DONE, DC_RDATA, DC_RVALID, DC_DONE, BEAT_IDX, BUSY, MM_REQ, MM_WE,
         MM_ADDR, MM_WDATA, MM_WVALID} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b req=%b addr=%h icv=%b dcv=%b wv=%b idx=%0d, want all 0",
               BUSY, MM_REQ, MM_ADDR, IC_RVALID, DC_RVALID, MM_WVALID, BEAT_IDX);
    end
    MM_RVALID = 0; MM_ACK = 0; MM_WREADY = 0; RST_N = 1; last_dc = 0;
    step;
  endtask

  task automatic test_ic_read;
    IC_REQ = 1; IC_ADDR = 32'h0000_1234; DC_WE = 1;
    do_burst(0, 0, 32'h0000_1230, 2, 0, 0, 0);
    IC_REQ = 0; DC_WE = 0;
  endtask

  task automatic test_contention;
    bit w;
    IC_REQ = 1; DC_REQ = 1; DC_WE = 0; IC_ADDR = $urandom; DC_ADDR = $urandom;
    for (int k = 0; k < 3; k++) begin
      w = pick_dc(1, 1);
      tests++;
      if (w !== (k != 1)) begin
        fails++;
        $display("FAIL rr_model: round %0d winner_dc=%b, want %b", k, w, k != 1);
      end
      do_burst(w, 0, (w ? DC_ADDR : IC_ADDR) & MASK, $urandom_range(0, 2), 0, 0, 0);
    end
    IC_REQ = 0; DC_REQ = 0;
  endtask

  task automatic test_writeback;
    DC_REQ = 1; DC_WE = 1; DC_ADDR = 32'h0000_2000;
    do_burst(1, 1, 32'h0000_2000, 1, 0, 0, 1);
    DC_REQ = 0; DC_WE = 0;
  endtask

  task automatic test_reset_mid;
    IC_REQ = 1; IC_ADDR = $urandom;
    step;
    MM_ACK = 1; step; MM_ACK = 0;
    for (int b = 0; b < 2; b++) begin MM_RVALID = 1; MM_RDATA = $urandom; step; end
    MM_RVALID = 1; #1;
    tests++;
    if (IC_RVALID !== 1'b1 || BEAT_IDX !== bidx_t'(2)) begin
      fails++;
      $display("FAIL mid_beat2: icv=%b idx=%0d, want 1 2", IC_RVALID, BEAT_IDX);
    end
    RST_N = 0;
    step;
    tests++;
    if (BUSY !== 1'b0 || MM_REQ !== 1'b0 || IC_DONE !== 1'b0 || IC_RVALID !== 1'b0 || IC_RDATA !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: busy=%b req=%b done=%b icv=%b, want 0 0 0 0", BUSY, MM_REQ, IC_DONE, IC_RVALID);
    end
    RST_N = 1; MM_RVALID = 0; last_dc = 0;
    do_burst(0, 0, IC_ADDR & MASK, 0, 20, 0, 0);
    IC_REQ = 0;
  endtask

  task automatic test_rvalid_in_addr;
    IC_REQ = 1; IC_ADDR = $urandom;
    do_burst(0, 0, IC_ADDR & MASK, 3, 0, 1, 0);
    IC_REQ = 0;
  endtask

  task automatic test_random;
    int combo;
    bit ic, dc, w;
    for (int n = 0; n < 30; n++) begin
      combo = $urandom_range(1, 3);
      ic = combo[0]; dc = combo[1];
      IC_ADDR = $urandom; DC_ADDR = $urandom; DC_WE = $urandom_range(0, 1);
      IC_REQ = ic; DC_REQ = dc;
      w = pick_dc(ic, dc);
      do_burst(w, w & DC_WE, (w ? DC_ADDR : IC_ADDR) & MASK, $urandom_range(0, 3), 30, $urandom_range(0, 1), 0);
    end
    IC_REQ = 0; DC_REQ = 0; DC_WE = 0;
  endtask

  task automatic test_wpl8;
    logic [31:0] d;
    DC_REQ_8 = 1; DC_ADDR_8 = 32'h0000_3FFC;
    step;
    tests++;
    if (MM_REQ_8 !== 1'b1 || MM_ADDR_8 !== 32'h0000_3FE0 || MM_WE_8 !== 1'b0) begin
      fails++;
      $display("FAIL w8_addr: req=%b addr=%h we=%b, want 1 00003fe0 0", MM_REQ_8, MM_ADDR_8, MM_WE_8);
    end
    MM_ACK_8 = 1; step; MM_ACK_8 = 0;
    for (int b = 0; b < 8; b++) begin
      d = $urandom;
      MM_RVALID_8 = 1; MM_RDATA_8 = d; #1;
      tests++;
      if (DC_RVALID_8 !== 1'b1 || DC_RDATA_8 !== d || BEAT_IDX_8 !== 3'(b) || IC_RVALID_8 !== 1'b0) begin
        fails++;
        $display("FAIL w8_beat%0d: v=%b d=%h idx=%0d icv=%b, want 1 %h %0d 0", b, DC_RVALID_8, DC_RDATA_8, BEAT_IDX_8, IC_RVALID_8, d, b);
      end
      step;
    end
    MM_RVALID_8 = 0; DC_REQ_8 = 0;
    tests++;
    if (DC_DONE_8 !== 1'b1 || IC_DONE_8 !== 1'b0) begin
      fails++;
      $display("FAIL w8_done: dc_done=%b ic_done=%b, want 1 0", DC_DONE_8, IC_DONE_8);
    end
    step;
    tests++;
    if (BUSY_8 !== 1'b0 || DC_DONE_8 !== 1'b0) begin
      fails++;
      $display("FAIL w8_idle: busy=%b done=%b, want 0 0", BUSY_8, DC_DONE_8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ic_read;
    test_contention;
    test_writeback;
    test_reset_mid;
    test_rvalid_in_addr;
    test_random;
    test_wpl8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
